seg_display_ctrl: RTL

Parametrised display controller that takes a binary value and drives a bank of seven-segment digits directly. It converts signed two's-complement input to decimal sequentially (double-dabble), blanks leading zeros, places a floating minus sign and flags overflow, with a hex pass-through mode. It sits between the sensor-readout logic (I2C accelerometer data, push-button selection) and the board's seven-segment pins, replacing the raw 24-bit BCD export with decoded segment outputs.

---
 rtl/seg_display_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// Signed binary / hex value to seven-segment digit bank, with sequential
// double-dabble conversion, leading-zero blanking, floating minus and overflow.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   in_valid/in_ready handshake; transfer when both high at a rising edge
//   in_data, hex_mode value and mode, sampled only at the transfer edge
//   seg               DIGITS*7 segments, digit 0 rightmost, bit 0 = a
//   overflow          value did not fit, registered with seg
//   done              one-cycle pulse when seg/overflow update
module seg_display_ctrl #(
  parameter int DATA_W         = 16,
  parameter int DIGITS         = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                hex_mode,
  output logic [DIGITS*7-1:0] seg,
  output logic                overflow,
  output logic                done
);

  localparam int BW = DIGITS * 4;
  localparam int SW = DIGITS * 7;
  localparam int XW = (DATA_W > BW) ? DATA_W : BW;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [6:0] DASH = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FMT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mag;
  logic              r_hex;
  logic              r_sign;
  logic              r_sof;
  logic [BW-1:0]     r_bcd;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_seg;
  logic              r_ovf;
  logic              r_done;

  logic [BW-1:0]     w_bcd_adj;
  logic [XW-1:0]     w_hx;
  logic [SW-1:0]     w_dec_seg;
  logic [SW-1:0]     w_hex_seg;
  logic [SW-1:0]     w_seg_pol;
  logic              w_dec_ovf;
  logic              w_hex_ovf;

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign in_ready = (r_state == IDLE);
  assign seg      = r_seg;
  assign overflow = r_ovf;
  assign done     = r_done;

  // Add-3 correction applied before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Decimal formatting: blank above the most significant nonzero
  // digit, minus just left of it when negative.
  always_comb begin
    int w_msd;
    w_msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] != 4'd0) w_msd = k;
    end
    w_dec_ovf = r_sof | (r_sign & (r_bcd[BW-1 -: 4] != 4'd0));
    w_dec_seg = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_dec_ovf) begin
        w_dec_seg[7*k +: 7] = DASH;
      end else if (k <= w_msd) begin
        w_dec_seg[7*k +: 7] = f_seg7(r_bcd[4*k +: 4]);
      end else if (r_sign && (k == w_msd + 1)) begin
        w_dec_seg[7*k +: 7] = DASH;
      end
    end
  end

  assign w_hx = XW'(r_data);

  always_comb begin
    w_hex_seg = '0;
    w_hex_ovf = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      w_hex_seg[7*k +: 7] = f_seg7(w_hx[4*k +: 4]);
    end
    for (int i = BW; i < XW; i++) begin
      w_hex_ovf = w_hex_ovf | w_hx[i];
    end
  end

  assign w_seg_pol = (r_hex ? w_hex_seg : w_dec_seg)
                   ^ {SW{SEG_ACTIVE_LOW}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_next = hex_mode ? FMT : CONV;
      end
      CONV: begin
        if (r_cnt == CW'(1)) w_next = FMT;
      end
      FMT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_mag  <= '0;
      r_hex  <= 1'b0;
      r_sign <= 1'b0;
      r_sof  <= 1'b0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_seg  <= {SW{SEG_ACTIVE_LOW}};
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_hex  <= hex_mode;
            r_sign <= in_data[DATA_W-1];
            // Most negative input wraps to 2^(DATA_W-1) unsigned.
            r_mag  <= in_data[DATA_W-1] ? -in_data : in_data;
            r_bcd  <= '0;
            r_sof  <= 1'b0;
            r_cnt  <= CW'(DATA_W);
          end
        end
        CONV: begin
          r_bcd <= {w_bcd_adj[BW-2:0], r_mag[DATA_W-1]};
          r_mag <= {r_mag[DATA_W-2:0], 1'b0};
          r_sof <= r_sof | w_bcd_adj[BW-1];
          r_cnt <= r_cnt - CW'(1);
        end
        FMT: begin
          r_seg  <= w_seg_pol;
          r_ovf  <= r_hex ? w_hex_ovf : w_dec_ovf;
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
